// File: rtl/clock_set_pkg.sv
// clock_set_pkg
// Shared definitions for the clock time-setting sequencer.
//  - state_t       : mode FSM encoding. The codes match the oSet field codes so that
//                    the state register drives oSet directly.
//  - FIELD_*       : oSet field codes seen by the FND mux.
//  - DEF_*         : default tick constants (all counted in 10 ms ticks).
package clock_set_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_MIN  = 2'b01,
    SET_HOUR = 2'b10
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_MIN  = 2'b01;
  localparam logic [1:0] FIELD_HOUR = 2'b10;

  localparam int DEF_REPEAT_DLY = 50;    // 500 ms before auto-repeat starts
  localparam int DEF_REPEAT_PER = 10;    // 100 ms between repeats
  localparam int DEF_TIMEOUT    = 1000;  // 10 s of inactivity leaves set mode
  localparam int DEF_BLINK_HALF = 50;    // 500 ms blink half-period
  localparam int DEF_CNT_W      = 10;    // must hold DEF_TIMEOUT

endpackage

// File: rtl/set_btn_repeat.sv
// set_btn_repeat
// Turns the debounced U/D button levels into single-clock up/down pulses.
// A rising edge gives one pulse; with CLOCK_SET_AUTOREPEAT_EN defined, holding exactly
// one of the two buttons also fires a pulse after REPEAT_DLY ticks and then every
// REPEAT_PER ticks. Pulses are combinational; the top registers them.
// Ports:
//  iClk, iRst      clock, asynchronous active-low reset
//  iTick           one-clock 10 ms strobe
//  iEnable         pulses allowed (set mode active); low also clears the repeat count
//  iClear          field change: restart the repeat count
//  iBtnU, iBtnD    debounced button levels, active-high
//  oUp, oDown      one-clock pulses, never both high
// Configuration macro: CLOCK_SET_AUTOREPEAT_EN (hold-to-repeat present when defined).
module set_btn_repeat #(
  parameter int CNT_W      = 10,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iTick,
  input  logic iEnable,
  input  logic iClear,
  input  logic iBtnU,
  input  logic iBtnD,
  output logic oUp,
  output logic oDown
);

  logic prevU, prevD;
  logic edgeU, edgeD;
  logic bothHeld;

  assign edgeU    = iBtnU & ~prevU;
  assign edgeD    = iBtnD & ~prevD;
  assign bothHeld = iBtnU & iBtnD;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      prevU <= 1'b0;
      prevD <= 1'b0;
    end else begin
      prevU <= iBtnU;
      prevD <= iBtnD;
    end
  end

`ifdef CLOCK_SET_AUTOREPEAT_EN
  logic [CNT_W-1:0] repCnt;
  logic             oneHeld;
  logic             repFire;

  assign oneHeld = iBtnU ^ iBtnD;
  assign repFire = iEnable & oneHeld & iTick & (repCnt == CNT_W'(REPEAT_DLY - 1));

  // After the first repeat the count is rewound by REPEAT_PER, so subsequent
  // fires land every REPEAT_PER ticks on the same compare value.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      repCnt <= '0;
    end else if (!iEnable || iClear || !oneHeld || edgeU || edgeD) begin
      repCnt <= '0;
    end else if (iTick) begin
      if (repCnt == CNT_W'(REPEAT_DLY - 1)) repCnt <= CNT_W'(REPEAT_DLY - REPEAT_PER);
      else                                   repCnt <= repCnt + 1'b1;
    end
  end

  assign oUp   = iEnable & ~bothHeld & (edgeU | (repFire & iBtnU));
  assign oDown = iEnable & ~bothHeld & (edgeD | (repFire & iBtnD));
`else
  // Without repeat the tick, clear and counter parameters have no function.
  localparam int unusedRepeatParams = CNT_W + REPEAT_DLY + REPEAT_PER;
  logic unusedRepeatIns;
  assign unusedRepeatIns = iTick ^ iClear;

  assign oUp   = iEnable & ~bothHeld & edgeU;
  assign oDown = iEnable & ~bothHeld & edgeD;
`endif

endmodule

// File: rtl/clock_set_sequencer.sv
// clock_set_sequencer
// Sequences time-setting of the clock datapath: RUN/SET_HOUR/SET_MIN mode FSM,
// U/D buttons -> single-clock hour/minute up/down strobes (optional hold-to-repeat),
// inactivity timeout back to RUN, and a blink flag for the selected field.
// Ports:
//  iClk, iRst              clock, asynchronous active-low reset
//  iTick_10ms              one-clock strobe every 10 ms
//  iSet_En                 set mode allowed (level)
//  iBtn_U/D/L/R            debounced button levels, active-high
//  oHour_Up/Down           one-clock hour strobes (registered)
//  oMin_Up/Down            one-clock minute strobes (registered)
//  oSet                    2'b10 hour, 2'b01 minute, 2'b00 running; this is the FSM state
//  oBlink                  1 = selected field blanked (registered)
// Configuration macro: CLOCK_SET_AUTOREPEAT_EN (hold-to-repeat, see set_btn_repeat).
// Handshake: there is no valid/ready; every strobe is a single-cycle pulse that the
// datapath must consume in the cycle it is high.
module clock_set_sequencer
  import clock_set_pkg::*;
#(
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int BLINK_HALF = DEF_BLINK_HALF,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTick_10ms,
  input  logic       iSet_En,
  input  logic       iBtn_U,
  input  logic       iBtn_D,
  input  logic       iBtn_L,
  input  logic       iBtn_R,
  output logic       oHour_Up,
  output logic       oHour_Down,
  output logic       oMin_Up,
  output logic       oMin_Down,
  output logic [1:0] oSet,
  output logic       oBlink
);

  state_t           state, nextState;
  logic             prevL, prevR;
  logic             edgeL, edgeR;
  logic             inSet, setActive, anyHeld;
  logic             timeoutHit, fieldChange;
  logic             upPulse, downPulse, anyStrobe;
  logic [CNT_W-1:0] toCnt, toCntNext;
  logic [CNT_W-1:0] blinkCnt, blinkCntNext;
  logic             blinkNext;
  logic             hourUpNext, hourDownNext, minUpNext, minDownNext;

  assign edgeL      = iBtn_L & ~prevL;
  assign edgeR      = iBtn_R & ~prevR;
  assign inSet      = (state != RUN);
  assign setActive  = inSet & iSet_En;
  assign anyHeld    = iBtn_U | iBtn_D | iBtn_L | iBtn_R;
  // A held button keeps the timeout counter cleared, so a hit implies no button activity.
  assign timeoutHit = setActive & iTick_10ms & ~anyHeld & (toCnt == CNT_W'(TIMEOUT - 1));
  assign fieldChange = setActive & (nextState != state) & (nextState != RUN);

  // State register
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= RUN;
    else       state <= nextState;
  end

  // Next-state logic: dropping iSet_En wins over everything else.
  always_comb begin
    nextState = state;
    case (state)
      RUN:      if (iSet_En) nextState = SET_HOUR;
      SET_HOUR: begin
        if (!iSet_En || timeoutHit) nextState = RUN;
        else if (edgeR && !edgeL)   nextState = SET_MIN;
      end
      SET_MIN:  begin
        if (!iSet_En || timeoutHit) nextState = RUN;
        else if (edgeL && !edgeR)   nextState = SET_HOUR;
      end
      default:  nextState = RUN;
    endcase
  end

  set_btn_repeat #(
    .CNT_W      (CNT_W),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) uBtnRepeat (
    .iClk    (iClk),
    .iRst    (iRst),
    .iTick   (iTick_10ms),
    .iEnable (setActive),
    .iClear  (fieldChange),
    .iBtnU   (iBtn_U),
    .iBtnD   (iBtn_D),
    .oUp     (upPulse),
    .oDown   (downPulse)
  );

  assign anyStrobe = upPulse | downPulse;

  // Output logic: next values of the registered outputs and counters.
  // Strobes are steered by the current state, so a same-cycle field move still edits
  // the field that was selected when the edge arrived.
  always_comb begin
    hourUpNext   = (state == SET_HOUR) & upPulse;
    hourDownNext = (state == SET_HOUR) & downPulse;
    minUpNext    = (state == SET_MIN)  & upPulse;
    minDownNext  = (state == SET_MIN)  & downPulse;

    toCntNext = toCnt;
    if (!setActive || anyHeld || timeoutHit) toCntNext = '0;
    else if (iTick_10ms)                     toCntNext = toCnt + 1'b1;

    blinkNext    = oBlink;
    blinkCntNext = blinkCnt;
    if (!inSet || nextState == RUN) begin
      blinkNext    = 1'b0;
      blinkCntNext = '0;
    end else if (anyStrobe || fieldChange) begin
      // Keep the field visible while it is being edited.
      blinkNext    = 1'b0;
      blinkCntNext = '0;
    end else if (iTick_10ms) begin
      if (blinkCnt == CNT_W'(BLINK_HALF - 1)) begin
        blinkNext    = ~oBlink;
        blinkCntNext = '0;
      end else begin
        blinkCntNext = blinkCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      prevL      <= 1'b0;
      prevR      <= 1'b0;
      toCnt      <= '0;
      blinkCnt   <= '0;
      oBlink     <= 1'b0;
      oHour_Up   <= 1'b0;
      oHour_Down <= 1'b0;
      oMin_Up    <= 1'b0;
      oMin_Down  <= 1'b0;
    end else begin
      prevL      <= iBtn_L;
      prevR      <= iBtn_R;
      toCnt      <= toCntNext;
      blinkCnt   <= blinkCntNext;
      oBlink     <= blinkNext;
      oHour_Up   <= hourUpNext;
      oHour_Down <= hourDownNext;
      oMin_Up    <= minUpNext;
      oMin_Down  <= minDownNext;
    end
  end

  assign oSet = state;

endmodule

// File: tb/tb_clock_set_sequencer.sv
module tb_clock_set_sequencer;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iTick_10ms = 1'b0;
  logic       iSet_En = 1'b0;
  logic       iBtn_U = 1'b0;
  logic       iBtn_D = 1'b0;
  logic       iBtn_L = 1'b0;
  logic       iBtn_R = 1'b0;
  logic       oHour_Up, oHour_Down, oMin_Up, oMin_Down;
  logic [1:0] oSet;
  logic       oBlink;

  localparam logic [3:0] S_HOUR_UP = 4'b1000;
  localparam logic [3:0] S_HOUR_DN = 4'b0100;
  localparam logic [3:0] S_MIN_DN  = 4'b0001;

  logic [3:0] exp_q[$];
  logic [3:0] strobes;
  int checks = 0;
  int errors = 0;

  assign strobes = {oHour_Up, oHour_Down, oMin_Up, oMin_Down};

  clock_set_sequencer dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iTick_10ms (iTick_10ms),
    .iSet_En    (iSet_En),
    .iBtn_U     (iBtn_U),
    .iBtn_D     (iBtn_D),
    .iBtn_L     (iBtn_L),
    .iBtn_R     (iBtn_R),
    .oHour_Up   (oHour_Up),
    .oHour_Down (oHour_Down),
    .oMin_Up    (oMin_Up),
    .oMin_Down  (oMin_Down),
    .oSet       (oSet),
    .oBlink     (oBlink)
  );

  // ---------------- clock ----------------
  always #5 iClk = ~iClk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every strobe the DUT presents must match the oldest expectation.
  always @(negedge iClk) begin
    if (iRst && strobes != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %b, expected none (t=%0t)", strobes, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("strobe", 32'(strobes), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic tick();
    iTick_10ms = 1'b1;
    step(1);
    iTick_10ms = 1'b0;
    step(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_lr(input logic l, input logic r);
    iBtn_L = l;
    iBtn_R = r;
    step(1);
    iBtn_L = 1'b0;
    iBtn_R = 1'b0;
    step(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    step(2);
    check("reset_oSet", 32'(oSet), 32'd0);
    check("reset_strobes", 32'(strobes), 32'd0);
    check("reset_oBlink", 32'(oBlink), 32'd0);
    iRst = 1'b1;
    step(2);
    check("idle_run", 32'(oSet), 32'd0);

    // 1: async reset mid SET_MIN with D held
    iSet_En = 1'b1;
    step(1);
    check("enter_set_hour", 32'(oSet), 32'h2);
    press_lr(1'b0, 1'b1);
    check("r_to_min", 32'(oSet), 32'h1);
    iBtn_D = 1'b1;
    exp_q.push_back(S_MIN_DN);
    step(1);
    step(3);
    #3;
    iRst = 1'b0;
    #1;
    check("async_rst_oSet", 32'(oSet), 32'd0);
    check("async_rst_strobes", 32'(strobes), 32'd0);
    check("async_rst_oBlink", 32'(oBlink), 32'd0);
    iBtn_D = 1'b0;
    iSet_En = 1'b0;
    step(2);
    iRst = 1'b1;
    step(2);
    check("after_rst_run", 32'(oSet), 32'd0);

    // 2: U press for one tick in SET_HOUR
    iSet_En = 1'b1;
    step(1);
    check("set_hour_again", 32'(oSet), 32'h2);
    iBtn_U = 1'b1;
    exp_q.push_back(S_HOUR_UP);
    step(1);
    check("hour_up_one_clk", 32'(oHour_Up), 32'd1);
    tick();
    iBtn_U = 1'b0;
    step(1);
    check("hour_up_single", 32'(strobes), 32'd0);

    // 3: hold D for 80 ticks in SET_MIN
    press_lr(1'b0, 1'b1);
    check("min_for_hold", 32'(oSet), 32'h1);
    iBtn_D = 1'b1;
    exp_q.push_back(S_MIN_DN);
`ifdef CLOCK_SET_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(S_MIN_DN);  // ticks 50,60,70,80
`endif
    step(1);
    ticks(80);
    iBtn_D = 1'b0;
    step(2);
    check("hold_strobes_done", 32'(exp_q.size()), 32'd0);

    // 4: field navigation
    press_lr(1'b1, 1'b0);
    check("l_to_hour", 32'(oSet), 32'h2);
    check("blink_off_on_move", 32'(oBlink), 32'd0);
    press_lr(1'b1, 1'b0);
    check("l_in_hour_ignored", 32'(oSet), 32'h2);
    press_lr(1'b0, 1'b1);
    check("r_to_min_2", 32'(oSet), 32'h1);
    press_lr(1'b1, 1'b1);
    check("l_r_together", 32'(oSet), 32'h1);
    press_lr(1'b1, 1'b0);
    check("back_to_hour", 32'(oSet), 32'h2);

    // 5: U and D together, held 100 ticks -> no strobes, no timeout
    iBtn_U = 1'b1;
    iBtn_D = 1'b1;
    step(1);
    ticks(100);
    iBtn_U = 1'b0;
    iBtn_D = 1'b0;
    step(2);
    check("ud_no_timeout", 32'(oSet), 32'h2);

    // 6a: inactivity timeout from SET_HOUR; field moves restart the blink phase
    press_lr(1'b0, 1'b1);
    press_lr(1'b1, 1'b0);
    check("timeout_start_hour", 32'(oSet), 32'h2);
    check("timeout_start_blink", 32'(oBlink), 32'd0);
    ticks(50);
    check("blink_first_toggle", 32'(oBlink), 32'd1);
    ticks(949);
    check("before_timeout_set", 32'(oSet), 32'h2);
    check("before_timeout_blink", 32'(oBlink), 32'd1);
    iTick_10ms = 1'b1;
    step(1);
    iTick_10ms = 1'b0;
    check("timeout_run", 32'(oSet), 32'd0);
    check("timeout_blink", 32'(oBlink), 32'd0);
    step(1);
    check("reenter_set", 32'(oSet), 32'h2);

    // 6b: iSet_En drops mid-repeat
    iBtn_U = 1'b1;
    exp_q.push_back(S_HOUR_UP);
`ifdef CLOCK_SET_AUTOREPEAT_EN
    exp_q.push_back(S_HOUR_UP);  // tick 50
`endif
    step(1);
    ticks(55);
    iSet_En = 1'b0;
    step(1);
    check("set_en_off_run", 32'(oSet), 32'd0);
    ticks(20);
    iBtn_U = 1'b0;
    step(2);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
